// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address/data widths and the matching
// typedefs, used by the register file and by its write-back scheduler.
package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam int NREGS  = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational. i_ptr names the requester with
// the highest priority; the search walks ptr, ptr+1, ... modulo NREQ and
// grants the first active request. At most one grant bit is ever set.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_gnt_idx
);

   logic [PW:0]   w_sum;
   logic [PW-1:0] w_idx;
   logic          w_found;

   // Rotating priority search starting at the pointer.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(NREQ)) begin
            w_sum = w_sum - (PW+1)'(NREQ);
         end
         w_idx = w_sum[PW-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file's single write port.
// Requesters share the port through a round-robin arbiter; the winning
// write is registered and presented to the register file one cycle later.
// A busy scoreboard marks destinations reserved at issue and frees them
// when their write reaches the register file, so decode can stall on RAW.
module regfile_wb_sched
   import regfile_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 rsv_valid,
   input  logic [AW-1:0]        rsv_addr,
   input  logic [AW-1:0]        rd_addr0,
   input  logic [AW-1:0]        rd_addr1,
   output logic                 rd_busy0,
   output logic                 rd_busy1,
   output logic                 rsv_dup,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        wr_data,
   output logic [(1<<AW)-1:0]   busy_vec
);

   localparam int NR = 1 << AW;
   localparam int PW = (NREQ > 2) ? 2 : 1;

   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_gnt_idx;
   logic            w_xfer;

   logic [AW-1:0]   w_addr_arr [NREQ];
   logic [DW-1:0]   w_data_arr [NREQ];
   logic [AW-1:0]   w_sel_addr;
   logic [DW-1:0]   w_sel_data;

   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   logic [DW-1:0]   r_wr_data;

   logic [NR-1:0]   r_busy;
   logic [NR-1:0]   w_set;
   logic [NR-1:0]   w_clr;
   logic            w_dup;
   logic            r_rsv_dup;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   // Grants are suppressed while reset is held so nothing is accepted then.
   assign req_ready = w_gnt & {NREQ{~rst}};
   assign w_xfer    = |req_ready;

   // Unpack the flat requester buses into per-requester slices.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
         assign w_data_arr[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   assign w_sel_addr = w_addr_arr[w_gnt_idx];
   assign w_sel_data = w_data_arr[w_gnt_idx];

   // Round-robin pointer: the requester after the last winner gets priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   // Write stage: one-cycle register between arbitration and the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_xfer;
         if (w_xfer) begin
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
         end
      end
   end

   // Per-register set/clear decode for the scoreboard.
   generate
      for (gi = 0; gi < NR; gi++) begin : g_sb
         assign w_set[gi] = rsv_valid & (rsv_addr == AW'(gi));
         assign w_clr[gi] = r_wr_en & (r_wr_addr == AW'(gi));
      end
   endgenerate

   // A reservation of a register whose write retires this very cycle is a
   // fresh reservation, not a duplicate.
   assign w_dup = rsv_valid & r_busy[rsv_addr]
                & ~(r_wr_en & (r_wr_addr == rsv_addr));

   // Scoreboard update; set is applied after clear so a new reservation survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   // Duplicate-reservation flag, high for the single cycle after the event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsv_dup <= 1'b0;
      end else begin
         r_rsv_dup <= w_dup;
      end
   end

   assign rd_busy0 = r_busy[rd_addr0];
   assign rd_busy1 = r_busy[rd_addr1];
   assign rsv_dup  = r_rsv_dup;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed vectors drive the requesters and
// the reservation port; each accepted write is queued and a separate
// monitor pops the queue whenever the DUT drives wr_en.
module tb_regfile_wb_sched;

   localparam int NREQ = 2;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*AW-1:0]  req_addr  = '0;
   logic [NREQ*DW-1:0]  req_data  = '0;
   logic [NREQ-1:0]     req_ready;
   logic                rsv_valid = 1'b0;
   logic [AW-1:0]       rsv_addr  = '0;
   logic [AW-1:0]       rd_addr0  = '0;
   logic [AW-1:0]       rd_addr1  = '0;
   logic                rd_busy0;
   logic                rd_busy1;
   logic                rsv_dup;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [DW-1:0]       wr_data;
   logic [(1<<AW)-1:0]  busy_vec;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_bad = 0;

   regfile_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rd_addr0  (rd_addr0),
      .rd_addr1  (rd_addr1),
      .rd_busy0  (rd_busy0),
      .rd_busy1  (rd_busy1),
      .rsv_dup   (rsv_dup),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_vec  (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus: drive after the falling edge, check the grant,
   // and queue the write the bench expects to be accepted.
   task automatic cyc(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic rv, input logic [AW-1:0] ra,
                      input logic [1:0] exp_rdy, input string nm);
      wr_t e;
      @(negedge clk);
      req_valid = {v1, v0};
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      rsv_valid = rv;
      rsv_addr  = ra;
      #1;
      check(nm, 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy[0]) begin
         e.a = a0; e.d = d0; exp_q.push_back(e);
      end
      if (exp_rdy[1]) begin
         e.a = a1; e.d = d1; exp_q.push_back(e);
      end
      $display("cyc %s: valid=%b rsv=%b/%0d ready=%b", nm, {v1, v0}, rv, ra, req_ready);
   endtask

   task automatic idle(input string nm);
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 2'b00, nm);
   endtask

   // Monitor: every register-file write must match the oldest queued entry.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL wr_unexpected: got write addr=%0d data=%0h, expected none", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("mon_wr_addr", 64'(wr_addr), 64'(e.a));
               check("mon_wr_data", 64'(wr_data), 64'(e.d));
               $display("mon write addr=%0d data=%0h", wr_addr, wr_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int i0;
      int i1;
      i0 = 0;
      i1 = 0;
      rd_addr0 = 5'd7;
      rd_addr1 = 5'd9;

      // Power-up reset, with requests pending to show grants are held off.
      req_valid = 2'b11;
      #2 rst = 1'b1;
      #1;
      check("rst_wr_en",    64'(wr_en),     64'd0);
      check("rst_wr_addr",  64'(wr_addr),   64'd0);
      check("rst_wr_data",  64'(wr_data),   64'd0);
      check("rst_busy_vec", 64'(busy_vec),  64'd0);
      check("rst_rsv_dup",  64'(rsv_dup),   64'd0);
      check("rst_ready",    64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;

      // Build up some state, then reset asynchronously in mid-cycle.
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 2'b00, "pre_rsv12");
      cyc(1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 1'b0, '0, 2'b01, "pre_req5");
      @(negedge clk);
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd6};
      req_data  = {32'h0, 32'h66};
      rsv_valid = 1'b0;
      #1;
      check("pre_wr_en",  64'(wr_en),       64'd1);
      check("pre_busy12", 64'(busy_vec[12]), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_wr_en",   64'(wr_en),     64'd0);
      check("mid_rst_wr_addr", 64'(wr_addr),   64'd0);
      check("mid_rst_wr_data", 64'(wr_data),   64'd0);
      check("mid_rst_busy",    64'(busy_vec),  64'd0);
      check("mid_rst_dup",     64'(rsv_dup),   64'd0);
      check("mid_rst_ready",   64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;

      // Test 1: pointer back at 0, req0 wins; req1 holds and wins next.
      cyc(1'b1, 5'd3, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b0, '0, 2'b01, "t1_rdy0");
      cyc(1'b0, '0, '0, 1'b1, 5'd8, 32'hBB, 1'b0, '0, 2'b10, "t1_rdy1");
      check("t1_wr_en",   64'(wr_en),   64'd1);
      check("t1_wr_addr", 64'(wr_addr), 64'd3);
      check("t1_wr_data", 64'(wr_data), 64'hAA);
      idle("t1_idle");
      check("t1_wr_addr2", 64'(wr_addr), 64'd8);

      // Test 2: both requesters valid for 4 cycles, grants alternate 0,1,0,1.
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 5'(10 + i0), 32'hA000_0000 | 32'(i0),
             1'b1, 5'(20 + i1), 32'hB000_0000 | 32'(i1),
             1'b0, '0, (k % 2 == 0) ? 2'b01 : 2'b10, "t2_rdy");
         if (k > 0) check("t2_wr_en", 64'(wr_en), 64'd1);
         if (k % 2 == 0) i0++; else i1++;
      end
      idle("t2_tail");
      check("t2_wr_en_last", 64'(wr_en), 64'd1);
      idle("t2_done");
      check("t2_wr_en_off", 64'(wr_en), 64'd0);

      // Test 6: only req1 with pointer 0 -> granted at once; pointer wraps to 0.
      cyc(1'b0, '0, '0, 1'b1, 5'd15, 32'h1515, 1'b0, '0, 2'b10, "t6_req1");
      cyc(1'b1, 5'd16, 32'h1616, 1'b1, 5'd17, 32'h1717, 1'b0, '0, 2'b01, "t6_wrap");
      cyc(1'b0, '0, '0, 1'b1, 5'd17, 32'h1717, 1'b0, '0, 2'b10, "t6_req1b");
      idle("t6_idle");
      idle("t6_hold");
      check("t6_wr_en_off",  64'(wr_en),   64'd0);
      check("t6_addr_hold",  64'(wr_addr), 64'd17);
      check("t6_data_hold",  64'(wr_data), 64'h1717);

      // Test 3: reserve 7, then its write clears it the cycle after wr_en.
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 2'b00, "t3_rsv7");
      cyc(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0, 2'b01, "t3_req7");
      check("t3_busy7",    64'(busy_vec[7]), 64'd1);
      check("t3_rd_busy0", 64'(rd_busy0),    64'd1);
      idle("t3_wr");
      check("t3_busy7_wr", 64'(busy_vec[7]), 64'd1);
      idle("t3_after");
      check("t3_busy7_clr", 64'(busy_vec[7]), 64'd0);
      check("t3_rd_busy0_clr", 64'(rd_busy0), 64'd0);

      // Test 4: write of 9 retires while 9 is reserved again -> set wins, no dup.
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 2'b00, "t4_rsv9");
      cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0, 2'b10, "t4_req9");
      check("t4_busy9", 64'(busy_vec[9]), 64'd1);
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 2'b00, "t4_rsv9_wr");
      check("t4_wr_en", 64'(wr_en), 64'd1);
      idle("t4_after");
      check("t4_busy9_kept", 64'(busy_vec[9]), 64'd1);
      check("t4_rd_busy1",   64'(rd_busy1),    64'd1);
      check("t4_no_dup",     64'(rsv_dup),     64'd0);

      // Test 5: reserve 4 twice, two cycles apart -> one-cycle dup pulse.
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 2'b00, "t5_rsv4a");
      idle("t5_gap");
      check("t5_dup_first", 64'(rsv_dup),     64'd0);
      check("t5_busy4",     64'(busy_vec[4]), 64'd1);
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 2'b00, "t5_rsv4b");
      check("t5_dup_pre", 64'(rsv_dup), 64'd0);
      idle("t5_pulse");
      check("t5_dup_on",  64'(rsv_dup),     64'd1);
      check("t5_busy4b",  64'(busy_vec[4]), 64'd1);
      idle("t5_end");
      check("t5_dup_off", 64'(rsv_dup),     64'd0);
      check("t5_busy4c",  64'(busy_vec[4]), 64'd1);

      // Drain: every queued write must have been seen by the monitor.
      idle("drain0");
      idle("drain1");
      check("queue_drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
